gnn_0_example_load_sched: RTL and testbench
===========================================

// Module: gnn_0_example_load_sched
// PURPOSE
// - Sequencer in front of the load datapath. Accepts one 96-bit LOAD instruction from the ctrl module.
// - Splits the instruction into DRAM read chunks and pulses read_start once per chunk.
// - Steers the returned 512-bit beats into the on-chip buffer at consecutive line addresses.
// - Reports completion to ctrl with a single-cycle ap_done pulse.
// PARAMETERS
// - LOAD_INST_LENGTH    96   instruction width
// - C_M_AXI_ADDR_WIDTH  64   DRAM byte-address width
// - C_M_AXI_DATA_WIDTH  512  beat width (one buffer line = 64 B)
// - C_XFER_SIZE_WIDTH   32   transfer-size width
// - BUF_ADDR_WIDTH      11   buffer line-address width
// - MAX_CHUNK_LINES     16   max lines per read_start (1 KiB)
// PORTS
// - kernel_clk               in   1    clock
// - kernel_rst_n             in   1    synchronous active-low reset
// - ap_start                 in   1    instruction valid, 1-cycle pulse
// - ap_ready                 out  1    1 = idle, will accept ap_start
// - ap_done                  out  1    1-cycle completion pulse
// - ctrl_addr_offset         in   64   DRAM byte base, sampled with ap_start
// - ctrl_instruction         in   96   LOAD instruction, sampled with ap_start
// - dram_xfer_start_addr     out  64   chunk DRAM byte address
// - dram_xfer_size_in_bytes  out  32   chunk size in bytes
// - read_start               out  1    1-cycle chunk launch pulse
// - read_done                in   1    reader finished the chunk (pulse)
// - data_tvalid              in   1    beat valid
// - data_tready              out  1    beat accept
// - data_tlast               in   1    last beat (informational only)
// - data_tdata               in   512  beat payload
// - load_write_buffer_valid  out  1    buffer write strobe
// - load_write_buffer_addr   out  11   buffer line address
// - load_write_buffer_data   out  512  buffer write data
// BEHAVIOUR
// - Instruction fields:
//   - [5:0]   opcode (6'd1 = LOAD; any other value = NOP)
//   - [15:6]  reserved
//   - [31:16] DRAM line offset
//   - [47:32] buffer start line
//   - [63:48] line count N
//   - [79:64] reserved
//   - [95:80] byte count (ignored; N is authoritative)
// - Reset: all outputs 0 except ap_ready = 1; FSM goes to IDLE; counters are cleared.
// - A reset asserted mid-transfer aborts immediately. Any read_done or beats still in flight are then ignored until the next ap_start.
// - FSM: IDLE -> DECODE -> ISSUE -> XFER -> (ISSUE | DONE) -> IDLE.
// - IDLE:
//   - ap_start && ap_ready registers the instruction, the offset, and base = ctrl_addr_offset + {line_off, 6'b0}.
//   - ap_ready drops on the next cycle.
//   - ap_start while busy is ignored (no queueing).
// - DECODE:
//   - Opcode != 1 or N == 0: go to DONE; no read_start is issued.
//   - Otherwise: remaining = N, buf_ptr = buffer start[10:0].
// - ISSUE:
//   - chunk = min(remaining, MAX_CHUNK_LINES).
//   - Drive dram_xfer_start_addr = base and dram_xfer_size_in_bytes = chunk << 6.
//   - Pulse read_start for exactly 1 cycle. Addr and size are held stable until the next ISSUE.
//   - read_start is asserted 2 cycles after the ap_start sample edge.
// - XFER:
//   - data_tready = 1 while beats_rcvd < chunk; otherwise 0, so extra beats are back-pressured, never written.
//   - Each accepted beat (tvalid && tready), in the same cycle:
//     - load_write_buffer_valid = 1, addr = buf_ptr, data = data_tdata (combinational pass-through);
//     - buf_ptr increments.
//   - buf_ptr wraps modulo 2^11 (2047 -> 0).
//   - read_done is latched in a sticky flag, whether it arrives before, with, or after the last beat.
//   - Chunk completes when beats_rcvd == chunk && done flag set.
//   - On completion: base += chunk << 6; remaining -= chunk; clear the flag.
//   - Then go to ISSUE if remaining != 0, else DONE.
// - DONE: ap_done = 1 for one cycle. ap_ready = 1 on the following cycle (IDLE).
// - Widths:
//   - remaining and beats counters are 17 bits (N up to 65535).
//   - base arithmetic is 64-bit unsigned, no overflow check.
// STRUCTURE
// - Shared package holds:
//   - opcode constants LOAD_OP = 6'd1;
//   - instruction field lsb/msb localparams;
//   - FSM state encoding (3-bit);
//   - LINE_BYTES_LOG2 = 6.
// - One natural sub-module: gnn_0_example_load_inst_dec (combinational field slicer plus opcode/zero-length check).
// - Everything else is a single FSM with its counters.
// TESTING
// - LOAD N=2, line_off 0, buf 0, offset 0:
//   - one read_start with addr 0, size 128;
//   - 2 beats written to addr 0,1;
//   - ap_done 1 cycle after read_done.
// - LOAD N=40, line_off 4, buf 12, offset 0x1000:
//   - three read_starts, in order:
//     - addr 0x1100, size 1024;
//     - addr 0x1500, size 1024;
//     - addr 0x1900, size 512;
//   - buffer addrs 12..51.
// - Wrap: buf 2046, N=4:
//   - writes land at 2046, 2047, 0, 1;
//   - ap_done after the single chunk.
// - N=0 and opcode 6'd2 (NOP):
//   - no read_start, no buffer writes;
//   - ap_done 2 cycles after ap_start.
// - Ordering and back-pressure:
//   - read_done before the last beat: ap_done only after beat 2 of 2 is written;
//   - a 3rd extra beat is held with data_tready = 0;
//   - ap_start asserted while busy is ignored.
// - Reset mid-XFER (kernel_rst_n = 0 for 1 cycle after beat 5 of 16):
//   - all outputs 0, ap_ready = 1;
//   - a following LOAD N=2 completes normally.

Source files
------------

// File: rtl/gnn_0_example_load_sched_pkg.sv
// Shared constants, instruction field map and FSM encoding for the LOAD sequencer.
package gnn_0_example_load_sched_pkg;

    localparam int LOAD_INST_LENGTH   = 96;
    localparam int C_M_AXI_ADDR_WIDTH = 64;
    localparam int C_M_AXI_DATA_WIDTH = 512;
    localparam int C_XFER_SIZE_WIDTH  = 32;
    localparam int BUF_ADDR_WIDTH     = 11;
    localparam int MAX_CHUNK_LINES    = 16;
    localparam int CNT_WIDTH          = 17;
    localparam int LINE_BYTES_LOG2    = 6;

    localparam logic [5:0]           LOAD_OP       = 6'd1;
    localparam logic [CNT_WIDTH-1:0] MAX_CHUNK_CNT = 17'd16;

    localparam int OPCODE_LSB    = 0;
    localparam int OPCODE_MSB    = 5;
    localparam int LINE_OFF_LSB  = 16;
    localparam int LINE_OFF_MSB  = 31;
    localparam int BUF_START_LSB = 32;
    localparam int BUF_START_MSB = 47;
    localparam int LINE_CNT_LSB  = 48;
    localparam int LINE_CNT_MSB  = 63;
    localparam int BYTE_CNT_LSB  = 80;
    localparam int BYTE_CNT_MSB  = 95;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_XFER   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef struct packed {
        logic [15:0]               line_off;
        logic [BUF_ADDR_WIDTH-1:0] buf_start;
        logic [15:0]               line_cnt;
    } load_fields_t;

    function automatic logic [CNT_WIDTH-1:0] chunk_lines(input logic [CNT_WIDTH-1:0] remaining);
        if (remaining > MAX_CHUNK_CNT) begin
            chunk_lines = MAX_CHUNK_CNT;
        end else begin
            chunk_lines = remaining;
        end
    endfunction

endpackage

// File: rtl/gnn_0_example_load_inst_dec.sv
// Combinational LOAD instruction slicer; flags whether the instruction moves any lines.
module gnn_0_example_load_inst_dec
    import gnn_0_example_load_sched_pkg::*;
(
    input  logic [LOAD_INST_LENGTH-1:0] instruction,
    output load_fields_t                fields,
    output logic                        has_work
);

    logic [5:0] opcode_s;
    logic       unused_bits_s;

    // Field extraction; reserved bits and the byte count carry no meaning here.
    always_comb begin
        opcode_s         = instruction[OPCODE_MSB:OPCODE_LSB];
        fields.line_off  = instruction[LINE_OFF_MSB:LINE_OFF_LSB];
        fields.buf_start = instruction[BUF_START_LSB+BUF_ADDR_WIDTH-1:BUF_START_LSB];
        fields.line_cnt  = instruction[LINE_CNT_MSB:LINE_CNT_LSB];
        has_work         = (opcode_s == LOAD_OP) && (fields.line_cnt != 16'd0);
        unused_bits_s    = ^{instruction[15:6],
                             instruction[BUF_START_MSB:BUF_START_LSB+BUF_ADDR_WIDTH],
                             instruction[79:64],
                             instruction[BYTE_CNT_MSB:BYTE_CNT_LSB]};
    end

endmodule

// File: rtl/gnn_0_example_load_sched.sv
// LOAD sequencer: splits an instruction into DRAM read chunks and steers returned
// beats into consecutive on-chip buffer lines.
module gnn_0_example_load_sched
    import gnn_0_example_load_sched_pkg::*;
(
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          ap_start,
    output logic                          ap_ready,
    output logic                          ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
    output logic                          read_start,
    input  logic                          read_done,
    input  logic                          data_tvalid,
    output logic                          data_tready,
    input  logic                          data_tlast,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
    output logic                          load_write_buffer_valid,
    output logic [BUF_ADDR_WIDTH-1:0]     load_write_buffer_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_data
);

    load_fields_t                  dec_fields_s;
    logic                          dec_has_work_s;

    logic [2:0]                    state_r;
    logic                          ap_ready_r;
    logic                          ap_done_r;
    logic                          read_start_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0] xfer_addr_r;
    logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0] base_r;
    logic [15:0]                   line_cnt_r;
    logic [BUF_ADDR_WIDTH-1:0]     buf_start_r;
    logic                          has_work_r;
    logic [BUF_ADDR_WIDTH-1:0]     buf_ptr_r;
    logic [CNT_WIDTH-1:0]          remaining_r;
    logic [CNT_WIDTH-1:0]          chunk_r;
    logic [CNT_WIDTH-1:0]          beats_r;
    logic                          done_flag_r;

    logic                          tready_s;
    logic                          beat_accept_s;
    logic [CNT_WIDTH-1:0]          beats_next_s;
    logic                          chunk_done_s;
    logic [CNT_WIDTH-1:0]          issue_chunk_s;
    logic [CNT_WIDTH-1:0]          remaining_next_s;
    logic [C_M_AXI_ADDR_WIDTH-1:0] chunk_bytes_s;
    logic [C_M_AXI_ADDR_WIDTH-1:0] line_off_bytes_s;
    logic                          unused_tlast_s;

    gnn_0_example_load_inst_dec u_inst_dec (
        .instruction (ctrl_instruction),
        .fields      (dec_fields_s),
        .has_work    (dec_has_work_s)
    );

    // Beat acceptance and chunk completion; read_done and the accepting beat
    // count in the same cycle so completion needs no extra turnaround.
    always_comb begin
        if ((state_r == ST_XFER) && (beats_r < chunk_r)) begin
            tready_s = 1'b1;
        end else begin
            tready_s = 1'b0;
        end
        beat_accept_s    = data_tvalid && tready_s;
        beats_next_s     = beats_r + {16'd0, beat_accept_s};
        chunk_done_s     = (state_r == ST_XFER) && (beats_next_s == chunk_r)
                           && (done_flag_r || read_done);
        issue_chunk_s    = chunk_lines(remaining_r);
        remaining_next_s = remaining_r - chunk_r;
        chunk_bytes_s    = {41'd0, chunk_r, 6'd0};
        line_off_bytes_s = {42'd0, dec_fields_s.line_off, 6'd0};
        unused_tlast_s   = data_tlast;
    end

    // Buffer write port: pass-through of the accepted beat, zero otherwise.
    always_comb begin
        load_write_buffer_valid = beat_accept_s;
        if (beat_accept_s) begin
            load_write_buffer_addr = buf_ptr_r;
            load_write_buffer_data = data_tdata;
        end else begin
            load_write_buffer_addr = 11'd0;
            load_write_buffer_data = {C_M_AXI_DATA_WIDTH{1'b0}};
        end
    end

    // Sequencer FSM with its address, pointer and beat counters.
    always_ff @(posedge kernel_clk) begin
        if (!kernel_rst_n) begin
            state_r      <= ST_IDLE;
            ap_ready_r   <= 1'b1;
            ap_done_r    <= 1'b0;
            read_start_r <= 1'b0;
            xfer_addr_r  <= 64'd0;
            xfer_size_r  <= 32'd0;
            base_r       <= 64'd0;
            line_cnt_r   <= 16'd0;
            buf_start_r  <= 11'd0;
            has_work_r   <= 1'b0;
            buf_ptr_r    <= 11'd0;
            remaining_r  <= 17'd0;
            chunk_r      <= 17'd0;
            beats_r      <= 17'd0;
            done_flag_r  <= 1'b0;
        end else begin
            ap_done_r    <= 1'b0;
            read_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ap_start && ap_ready_r) begin
                        base_r      <= ctrl_addr_offset + line_off_bytes_s;
                        line_cnt_r  <= dec_fields_s.line_cnt;
                        buf_start_r <= dec_fields_s.buf_start;
                        has_work_r  <= dec_has_work_s;
                        ap_ready_r  <= 1'b0;
                        state_r     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (has_work_r) begin
                        remaining_r <= {1'b0, line_cnt_r};
                        buf_ptr_r   <= buf_start_r;
                        state_r     <= ST_ISSUE;
                    end else begin
                        ap_done_r   <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    chunk_r      <= issue_chunk_s;
                    xfer_addr_r  <= base_r;
                    xfer_size_r  <= {9'd0, issue_chunk_s, 6'd0};
                    read_start_r <= 1'b1;
                    beats_r      <= 17'd0;
                    done_flag_r  <= 1'b0;
                    state_r      <= ST_XFER;
                end
                ST_XFER: begin
                    beats_r <= beats_next_s;
                    if (beat_accept_s) begin
                        buf_ptr_r <= buf_ptr_r + 11'd1;
                    end
                    if (chunk_done_s) begin
                        base_r      <= base_r + chunk_bytes_s;
                        remaining_r <= remaining_next_s;
                        done_flag_r <= 1'b0;
                        if (remaining_next_s != 17'd0) begin
                            state_r <= ST_ISSUE;
                        end else begin
                            ap_done_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                    end else if (read_done) begin
                        done_flag_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    ap_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    ap_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ap_ready                = ap_ready_r;
    assign ap_done                 = ap_done_r;
    assign read_start              = read_start_r;
    assign dram_xfer_start_addr    = xfer_addr_r;
    assign dram_xfer_size_in_bytes = xfer_size_r;
    assign data_tready             = tready_s;

endmodule

// File: tb/tb_gnn_0_example_load_sched.sv
// Directed self-checking bench for the LOAD sequencer.
module tb_gnn_0_example_load_sched;

    logic         kernel_clk = 1'b0;
    logic         kernel_rst_n;
    logic         ap_start;
    logic         ap_ready;
    logic         ap_done;
    logic [63:0]  ctrl_addr_offset;
    logic [95:0]  ctrl_instruction;
    logic [63:0]  dram_xfer_start_addr;
    logic [31:0]  dram_xfer_size_in_bytes;
    logic         read_start;
    logic         read_done;
    logic         data_tvalid;
    logic         data_tready;
    logic         data_tlast;
    logic [511:0] data_tdata;
    logic         load_write_buffer_valid;
    logic [10:0]  load_write_buffer_addr;
    logic [511:0] load_write_buffer_data;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int gbeat     = 0;

    int          rs_cyc_q[$];
    logic [63:0] rs_addr_q[$];
    logic [31:0] rs_size_q[$];
    int          wr_cyc_q[$];
    logic [10:0] wr_addr_q[$];
    logic [63:0] wr_dat_q[$];
    int          done_cyc_q[$];

    gnn_0_example_load_sched dut (
        .kernel_clk              (kernel_clk),
        .kernel_rst_n            (kernel_rst_n),
        .ap_start                (ap_start),
        .ap_ready                (ap_ready),
        .ap_done                 (ap_done),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_instruction        (ctrl_instruction),
        .dram_xfer_start_addr    (dram_xfer_start_addr),
        .dram_xfer_size_in_bytes (dram_xfer_size_in_bytes),
        .read_start              (read_start),
        .read_done               (read_done),
        .data_tvalid             (data_tvalid),
        .data_tready             (data_tready),
        .data_tlast              (data_tlast),
        .data_tdata              (data_tdata),
        .load_write_buffer_valid (load_write_buffer_valid),
        .load_write_buffer_addr  (load_write_buffer_addr),
        .load_write_buffer_data  (load_write_buffer_data)
    );

    always #5 kernel_clk = ~kernel_clk;

    always @(posedge kernel_clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle.
    always @(negedge kernel_clk) begin
        if (read_start) begin
            rs_cyc_q.push_back(cyc);
            rs_addr_q.push_back(dram_xfer_start_addr);
            rs_size_q.push_back(dram_xfer_size_in_bytes);
        end
        if (load_write_buffer_valid) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(load_write_buffer_addr);
            wr_dat_q.push_back(load_write_buffer_data[63:0]);
        end
        if (ap_done) begin
            done_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] mk_inst(input logic [5:0] op, input logic [15:0] loff,
                                            input logic [15:0] bstart, input logic [15:0] n);
        logic [95:0] v;
        v        = 96'd0;
        v[5:0]   = op;
        v[31:16] = loff;
        v[47:32] = bstart;
        v[63:48] = n;
        v[95:80] = 16'hFFFF;
        return v;
    endfunction

    function automatic logic [63:0] pat64(input int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i);
    endfunction

    task automatic tick();
        @(posedge kernel_clk);
        #1;
    endtask

    task automatic clear_logs();
        rs_cyc_q.delete();
        rs_addr_q.delete();
        rs_size_q.delete();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_dat_q.delete();
        done_cyc_q.delete();
        gbeat = 0;
    endtask

    task automatic launch(input logic [95:0] inst, input logic [63:0] off);
        int w;
        w = 0;
        while (!ap_ready && w < 20) begin
            tick();
            w++;
        end
        chk("ready_before_start", 64'(ap_ready), 64'd1);
        ctrl_instruction = inst;
        ctrl_addr_offset = off;
        ap_start = 1'b1;
        tick();
        start_cyc = cyc;
        ap_start = 1'b0;
        ctrl_instruction = 96'd0;
        ctrl_addr_offset = 64'd0;
    endtask

    // mode: 0 read_done with last beat, 1 after last beat, 2 with first beat, 3 never
    task automatic serve_chunk(input int nbeats, input int mode, input bit busy_start, input bit extra);
        int   w;
        int   sent;
        int   guard;
        logic acc;
        w = 0;
        while (!read_start && w < 40) begin
            tick();
            w++;
        end
        chk("read_start_seen", 64'(read_start), 64'd1);
        if (!read_start) return;
        sent  = 0;
        guard = 0;
        while (sent < nbeats && guard < 200) begin
            data_tvalid = 1'b1;
            data_tdata  = {8{pat64(gbeat)}};
            data_tlast  = (sent == nbeats - 1);
            read_done   = (mode == 2 && sent == 0) || (mode == 0 && sent == nbeats - 1);
            if (busy_start && sent == 1) begin
                ap_start         = 1'b1;
                ctrl_instruction = mk_inst(6'd1, 16'd0, 16'd0, 16'd3);
            end
            acc = data_tready;
            tick();
            ap_start  = 1'b0;
            read_done = 1'b0;
            if (acc) begin
                sent++;
                gbeat++;
            end
            guard++;
        end
        data_tlast = 1'b0;
        if (extra) begin
            data_tvalid = 1'b1;
            data_tdata  = {8{pat64(999)}};
            chk("bp_tready_low", 64'(data_tready), 64'd0);
            tick();
        end
        if (mode == 1) begin
            read_done = 1'b1;
            tick();
            read_done = 1'b0;
        end
        data_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (done_cyc_q.size() == 0 && w < 80) begin
            tick();
            w++;
        end
        tick();
        tick();
        tick();
        chk("done_count", 64'(done_cyc_q.size()), 64'd1);
        chk("ready_after_done", 64'(ap_ready), 64'd1);
    endtask

    initial begin
        kernel_rst_n     = 1'b0;
        ap_start         = 1'b0;
        ctrl_addr_offset = 64'd0;
        ctrl_instruction = 96'd0;
        read_done        = 1'b0;
        data_tvalid      = 1'b0;
        data_tlast       = 1'b0;
        data_tdata       = 512'd0;
        repeat (3) tick();
        chk("rst_ap_ready", 64'(ap_ready), 64'd1);
        chk("rst_ap_done", 64'(ap_done), 64'd0);
        chk("rst_read_start", 64'(read_start), 64'd0);
        chk("rst_tready", 64'(data_tready), 64'd0);
        chk("rst_wr_valid", 64'(load_write_buffer_valid), 64'd0);
        chk("rst_xfer_addr", dram_xfer_start_addr, 64'd0);
        chk("rst_xfer_size", 64'(dram_xfer_size_in_bytes), 64'd0);
        kernel_rst_n = 1'b1;
        tick();

        // N=2 single chunk, read_done with the last beat
        clear_logs();
        launch(mk_inst(6'd1, 16'd0, 16'd0, 16'd2), 64'd0);
        serve_chunk(2, 0, 1'b0, 1'b0);
        wait_done();
        chk("n2_rs_count", 64'(rs_cyc_q.size()), 64'd1);
        chk("n2_wr_count", 64'(wr_cyc_q.size()), 64'd2);
        if (rs_cyc_q.size() >= 1) begin
            chk("n2_rs_latency", 64'(rs_cyc_q[0] - start_cyc), 64'd2);
            chk("n2_rs_addr", rs_addr_q[0], 64'd0);
            chk("n2_rs_size", 64'(rs_size_q[0]), 64'd128);
        end
        if (wr_cyc_q.size() >= 2 && done_cyc_q.size() >= 1) begin
            chk("n2_wr_addr0", 64'(wr_addr_q[0]), 64'd0);
            chk("n2_wr_addr1", 64'(wr_addr_q[1]), 64'd1);
            chk("n2_wr_data1", wr_dat_q[1], 64'hC0DE_0000_0000_0001);
            chk("n2_done_after_rd", 64'(done_cyc_q[0] - wr_cyc_q[1]), 64'd1);
        end

        // N=40 in three chunks
        clear_logs();
        launch(mk_inst(6'd1, 16'd4, 16'd12, 16'd40), 64'h1000);
        serve_chunk(16, 0, 1'b0, 1'b0);
        serve_chunk(16, 1, 1'b0, 1'b0);
        serve_chunk(8, 0, 1'b0, 1'b0);
        wait_done();
        chk("n40_rs_count", 64'(rs_cyc_q.size()), 64'd3);
        if (rs_cyc_q.size() >= 3) begin
            chk("n40_rs0_addr", rs_addr_q[0], 64'h1100);
            chk("n40_rs0_size", 64'(rs_size_q[0]), 64'd1024);
            chk("n40_rs1_addr", rs_addr_q[1], 64'h1500);
            chk("n40_rs1_size", 64'(rs_size_q[1]), 64'd1024);
            chk("n40_rs2_addr", rs_addr_q[2], 64'h1900);
            chk("n40_rs2_size", 64'(rs_size_q[2]), 64'd512);
        end
        chk("n40_wr_count", 64'(wr_cyc_q.size()), 64'd40);
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            chk($sformatf("n40_wr_addr%0d", i), 64'(wr_addr_q[i]), 64'(12 + i));
            chk($sformatf("n40_wr_data%0d", i), wr_dat_q[i], pat64(i));
        end

        // Buffer pointer wrap
        clear_logs();
        launch(mk_inst(6'd1, 16'd2, 16'd2046, 16'd4), 64'd0);
        serve_chunk(4, 0, 1'b0, 1'b0);
        wait_done();
        chk("wrap_rs_count", 64'(rs_cyc_q.size()), 64'd1);
        if (rs_cyc_q.size() >= 1) begin
            chk("wrap_rs_addr", rs_addr_q[0], 64'h80);
            chk("wrap_rs_size", 64'(rs_size_q[0]), 64'd256);
        end
        chk("wrap_wr_count", 64'(wr_cyc_q.size()), 64'd4);
        if (wr_addr_q.size() >= 4) begin
            chk("wrap_addr0", 64'(wr_addr_q[0]), 64'd2046);
            chk("wrap_addr1", 64'(wr_addr_q[1]), 64'd2047);
            chk("wrap_addr2", 64'(wr_addr_q[2]), 64'd0);
            chk("wrap_addr3", 64'(wr_addr_q[3]), 64'd1);
        end

        // N=0 LOAD: ap_start cycle is start_cyc-1, ap_done two cycles later
        clear_logs();
        launch(mk_inst(6'd1, 16'd5, 16'd0, 16'd0), 64'd0);
        wait_done();
        chk("n0_rs_count", 64'(rs_cyc_q.size()), 64'd0);
        chk("n0_wr_count", 64'(wr_cyc_q.size()), 64'd0);
        if (done_cyc_q.size() >= 1) begin
            chk("n0_done_lat", 64'(done_cyc_q[0] - (start_cyc - 1)), 64'd2);
        end

        // Opcode 2 is a NOP even with a nonzero count
        clear_logs();
        launch(mk_inst(6'd2, 16'd0, 16'd0, 16'd4), 64'd0);
        wait_done();
        chk("nop_rs_count", 64'(rs_cyc_q.size()), 64'd0);
        chk("nop_wr_count", 64'(wr_cyc_q.size()), 64'd0);
        if (done_cyc_q.size() >= 1) begin
            chk("nop_done_lat", 64'(done_cyc_q[0] - (start_cyc - 1)), 64'd2);
        end

        // read_done ahead of the last beat, plus an ap_start while busy
        clear_logs();
        launch(mk_inst(6'd1, 16'd0, 16'd20, 16'd2), 64'd0);
        serve_chunk(2, 2, 1'b1, 1'b0);
        wait_done();
        repeat (6) tick();
        chk("ord_rs_count", 64'(rs_cyc_q.size()), 64'd1);
        chk("ord_wr_count", 64'(wr_cyc_q.size()), 64'd2);
        chk("ord_done_count", 64'(done_cyc_q.size()), 64'd1);
        if (wr_cyc_q.size() >= 2 && done_cyc_q.size() >= 1) begin
            chk("ord_done_after_beat2", 64'(done_cyc_q[0] - wr_cyc_q[1]), 64'd1);
            chk("ord_wr_addr1", 64'(wr_addr_q[1]), 64'd21);
        end

        // Extra beat held off while waiting for read_done
        clear_logs();
        launch(mk_inst(6'd1, 16'd0, 16'd30, 16'd2), 64'd0);
        serve_chunk(2, 1, 1'b0, 1'b1);
        wait_done();
        chk("bp_wr_count", 64'(wr_cyc_q.size()), 64'd2);

        // Reset after beat 5 of 16 aborts; stray beats and read_done are ignored
        clear_logs();
        launch(mk_inst(6'd1, 16'd0, 16'd100, 16'd16), 64'd0);
        serve_chunk(5, 3, 1'b0, 1'b0);
        chk("rst_mid_wr_count", 64'(wr_cyc_q.size()), 64'd5);
        data_tvalid  = 1'b1;
        data_tdata   = {8{pat64(777)}};
        read_done    = 1'b1;
        kernel_rst_n = 1'b0;
        tick();
        kernel_rst_n = 1'b1;
        chk("abort_ap_ready", 64'(ap_ready), 64'd1);
        chk("abort_ap_done", 64'(ap_done), 64'd0);
        chk("abort_read_start", 64'(read_start), 64'd0);
        chk("abort_tready", 64'(data_tready), 64'd0);
        chk("abort_wr_valid", 64'(load_write_buffer_valid), 64'd0);
        chk("abort_wr_addr", 64'(load_write_buffer_addr), 64'd0);
        chk("abort_wr_data", load_write_buffer_data[63:0], 64'd0);
        chk("abort_xfer_addr", dram_xfer_start_addr, 64'd0);
        chk("abort_xfer_size", 64'(dram_xfer_size_in_bytes), 64'd0);
        tick();
        chk("abort_stray_tready", 64'(data_tready), 64'd0);
        chk("abort_stray_wr", 64'(load_write_buffer_valid), 64'd0);
        data_tvalid = 1'b0;
        read_done   = 1'b0;
        tick();
        clear_logs();
        launch(mk_inst(6'd1, 16'd1, 16'd7, 16'd2), 64'h40);
        serve_chunk(2, 0, 1'b0, 1'b0);
        wait_done();
        chk("post_rs_count", 64'(rs_cyc_q.size()), 64'd1);
        chk("post_wr_count", 64'(wr_cyc_q.size()), 64'd2);
        if (rs_cyc_q.size() >= 1) begin
            chk("post_rs_addr", rs_addr_q[0], 64'h80);
            chk("post_rs_size", 64'(rs_size_q[0]), 64'd128);
        end
        if (wr_addr_q.size() >= 2) begin
            chk("post_wr_addr0", 64'(wr_addr_q[0]), 64'd7);
            chk("post_wr_addr1", 64'(wr_addr_q[1]), 64'd8);
            chk("post_wr_data0", wr_dat_q[0], pat64(0));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
